// File: rtl/uart_cmd_parser.sv
// Command sequencer: pops bytes from the UART RX FIFO, assembles SYNC/OPCODE/ADDR/DATA packets and executes them.
// Optional build macro CMD_CHECKSUM_EN appends a CHK byte (OPCODE^ADDR^DATA) to every packet.
module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_fifo_data,
    input  logic       rx_fifo_empty,
    output logic       rx_fifo_read_enable,
    input  logic       frame_busy,
    output logic       start_write_frame,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       cmd_error,
    output logic [7:0] err_count
);

`ifdef CMD_CHECKSUM_EN
    localparam int unsigned PKT_LEN = 5;
`else
    localparam int unsigned PKT_LEN = 4;
`endif
    localparam int unsigned    IDX_W    = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
    localparam logic [7:0]     OP_WRITE = 8'h01;
    localparam logic [7:0]     OP_START = 8'h02;

    typedef enum logic [1:0] {
        FETCH,
        LATCH,
        EXEC
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [15:0]      tmo_cnt;
    logic [7:0]       op_q;
    logic [7:0]       addr_q;
    logic [7:0]       data_q;
    logic             start_pend;
    logic             tmo_hit;
    logic [7:0]       data_byte;
    logic             chk_ok;

    // Expiry wins over a byte that shows up in the same cycle; that byte starts a fresh packet.
    assign tmo_hit = (state == FETCH) && (idx != '0) && (tmo_cnt >= TIMEOUT_CYCLES);

    // The pop strobe must react to this cycle's empty flag, so it is decoded from state directly.
    assign rx_fifo_read_enable = !rst && (state == FETCH) && !rx_fifo_empty && !tmo_hit;

`ifdef CMD_CHECKSUM_EN
    assign data_byte = data_q;
    assign chk_ok    = (rx_fifo_data == (op_q ^ addr_q ^ data_q));
`else
    assign data_byte = rx_fifo_data;
    assign chk_ok    = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= FETCH;
            idx               <= '0;
            tmo_cnt           <= '0;
            op_q              <= '0;
            addr_q            <= '0;
            data_q            <= '0;
            start_pend        <= 1'b0;
            start_write_frame <= 1'b0;
            reg_wr_en         <= 1'b0;
            reg_wr_addr       <= '0;
            reg_wr_data       <= '0;
            cmd_error         <= 1'b0;
            err_count         <= '0;
        end else begin
            start_write_frame <= 1'b0;
            reg_wr_en         <= 1'b0;
            cmd_error         <= 1'b0;

            case (state)
                FETCH: begin
                    if (tmo_hit) begin
                        cmd_error <= 1'b1;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        idx       <= '0;
                        tmo_cnt   <= '0;
                    end else if (!rx_fifo_empty) begin
                        state   <= LATCH;
                        tmo_cnt <= '0;
                    end else if (idx != '0) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                LATCH: begin
                    state <= FETCH;
                    if (idx == '0) begin
                        if (rx_fifo_data == SYNC_BYTE) idx <= IDX_W'(1);
                    end else if (idx == LAST_IDX) begin
                        // Decide the command here so its strobe lands in the EXEC cycle.
                        state <= EXEC;
                        idx   <= '0;
                        if (!chk_ok) begin
                            cmd_error <= 1'b1;
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        end else if (op_q == OP_WRITE) begin
                            reg_wr_en   <= 1'b1;
                            reg_wr_addr <= addr_q;
                            reg_wr_data <= data_byte;
                        end else if (op_q == OP_START) begin
                            start_pend <= 1'b1;
                        end else begin
                            cmd_error <= 1'b1;
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        end
                    end else begin
                        case (idx)
                            IDX_W'(1): op_q   <= rx_fifo_data;
                            IDX_W'(2): addr_q <= rx_fifo_data;
                            default:   data_q <= rx_fifo_data;
                        endcase
                        idx <= idx + IDX_W'(1);
                    end
                end

                EXEC: begin
                    if (!start_pend) begin
                        state <= FETCH;
                    end else if (!frame_busy) begin
                        start_write_frame <= 1'b1;
                        start_pend        <= 1'b0;
                        state             <= FETCH;
                    end
                end

                default: state <= FETCH;
            endcase
        end
    end

endmodule
